// File: rtl/lv_lcd_controller.sv
// lv_lcd_controller: write-only HD44780 sequencer in 4-bit mode.
// Runs the power-on init sequence after reset, then accepts command/data
// bytes over a valid/ready handshake and sends each one as two E-strobed
// nibbles, followed by the controller execution delay.
// Optional build macro: LCD_LONG_CMD_DETECT_EN. When it is defined, only
// clear/home commands get the long post-delay. Otherwise every user byte
// gets the long post-delay.
//
// Handshake: a byte transfers on a cycle where Valid && Ready are both high.
// Ready depends only on internal state, never on Valid. Valid while not
// Ready is ignored, and there is no queue.
module lv_lcd_controller #(
    parameter int CLK_KHZ  = 48000,
    parameter int E_CYCLES = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Data,
    input  logic       RS_In,
    input  logic       Valid,
    output logic       Ready,
    output logic       Init_Done,
    output logic       LCD_RS,
    output logic       LCD_R_nW,
    output logic       LCD_E,
    output logic [3:0] LCD_D
);

    // Convert a microsecond delay to clock cycles, never less than 1
    function automatic logic [23:0] us_to_cyc(input longint us);
        longint c;
        c = (longint'(CLK_KHZ) * us) / 1000;
        if (c < 1) c = 1;
        return c[23:0];
    endfunction

    localparam logic [23:0] DLY_15000 = us_to_cyc(15000);
    localparam logic [23:0] DLY_4100  = us_to_cyc(4100);
    localparam logic [23:0] DLY_1640  = us_to_cyc(1640);
    localparam logic [23:0] DLY_100   = us_to_cyc(100);
    localparam logic [23:0] DLY_40    = us_to_cyc(40);
    localparam logic [23:0] E_LAST    = 24'(E_CYCLES - 1);

    typedef enum logic [2:0] {
        PWR_WAIT, INIT_STEP, IDLE, N_SETUP, N_HIGH, N_HOLD, POST_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;        // down-counter for the current state
    logic [23:0] dly_q, dly_d;        // post-delay of the byte in flight
    logic [3:0]  step_q, step_d;      // init ROM index
    logic        armed_q, armed_d;    // power-up wait has loaded its count
    logic        init_done_q, init_done_d;
    logic        rs_q, rs_d;
    logic [3:0]  nib_q, nib_d;        // nibble currently on the pins
    logic [3:0]  lo_q, lo_d;          // low nibble waiting to be sent
    logic        second_q, second_d;  // a low nibble is still pending

    logic        rom_is_byte;
    logic [7:0]  rom_byte;
    logic [23:0] rom_dly;
    logic [23:0] user_dly;

    // Init ROM. Nibble-only steps carry their nibble in the upper half.
    always_comb begin
        rom_is_byte = 1'b1;
        rom_byte    = 8'h0C;
        rom_dly     = DLY_40;
        case (step_q)
            4'd0: begin rom_is_byte = 1'b0; rom_byte = 8'h30; rom_dly = DLY_4100; end
            4'd1: begin rom_is_byte = 1'b0; rom_byte = 8'h30; rom_dly = DLY_100;  end
            4'd2: begin rom_is_byte = 1'b0; rom_byte = 8'h30; rom_dly = DLY_100;  end
            4'd3: begin rom_is_byte = 1'b0; rom_byte = 8'h20; rom_dly = DLY_100;  end
            4'd4: begin rom_byte = 8'h28; rom_dly = DLY_40;   end
            4'd5: begin rom_byte = 8'h08; rom_dly = DLY_40;   end
            4'd6: begin rom_byte = 8'h01; rom_dly = DLY_1640; end
            4'd7: begin rom_byte = 8'h06; rom_dly = DLY_40;   end
            default: begin rom_byte = 8'h0C; rom_dly = DLY_40; end
        endcase
    end

`ifdef LCD_LONG_CMD_DETECT_EN
    // Only clear (0x01) and home (0x02/0x03) need the long execution time
    assign user_dly = (!RS_In && (Data[7:2] == 6'd0)) ? DLY_1640 : DLY_40;
`else
    assign user_dly = DLY_1640;
`endif

    // Next-state logic: sequencing, counter loads and byte capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dly_d       = dly_q;
        step_d      = step_q;
        armed_d     = armed_q;
        init_done_d = init_done_q;
        rs_d        = rs_q;
        nib_d       = nib_q;
        lo_d        = lo_q;
        second_d    = second_q;
        case (state_q)
            PWR_WAIT: begin
                // The first cycle after reset loads the count, so the state lasts DLY_15000 cycles in total
                if (!armed_q) begin
                    armed_d = 1'b1;
                    cnt_d   = DLY_15000 - 24'd2;
                end else if (cnt_q == 24'd0) begin
                    state_d = INIT_STEP;
                    step_d  = 4'd0;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            INIT_STEP: begin
                nib_d    = rom_byte[7:4];
                lo_d     = rom_byte[3:0];
                second_d = rom_is_byte;
                rs_d     = 1'b0;
                dly_d    = rom_dly;
                cnt_d    = E_LAST;
                state_d  = N_SETUP;
            end
            IDLE: begin
                if (Valid && init_done_q) begin
                    nib_d    = Data[7:4];
                    lo_d     = Data[3:0];
                    second_d = 1'b1;
                    rs_d     = RS_In;
                    dly_d    = user_dly;
                    cnt_d    = E_LAST;
                    state_d  = N_SETUP;
                end
            end
            N_SETUP: begin
                if (cnt_q == 24'd0) begin
                    cnt_d   = E_LAST;
                    state_d = N_HIGH;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            N_HIGH: begin
                if (cnt_q == 24'd0) begin
                    cnt_d   = E_LAST;
                    state_d = N_HOLD;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            N_HOLD: begin
                if (cnt_q == 24'd0) begin
                    if (second_q) begin
                        nib_d    = lo_q;
                        second_d = 1'b0;
                        cnt_d    = E_LAST;
                        state_d  = N_SETUP;
                    end else begin
                        cnt_d   = dly_q - 24'd1;
                        state_d = POST_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            POST_WAIT: begin
                if (cnt_q == 24'd0) begin
                    if (init_done_q) begin
                        state_d = IDLE;
                    end else if (step_q == 4'd8) begin
                        init_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        step_d  = step_q + 4'd1;
                        state_d = INIT_STEP;
                    end
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            default: state_d = PWR_WAIT;
        endcase
    end

    // State registers with synchronous reset that abandons any transfer
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= PWR_WAIT;
            cnt_q       <= 24'd0;
            dly_q       <= 24'd0;
            step_q      <= 4'd0;
            armed_q     <= 1'b0;
            init_done_q <= 1'b0;
            rs_q        <= 1'b0;
            nib_q       <= 4'd0;
            lo_q        <= 4'd0;
            second_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dly_q       <= dly_d;
            step_q      <= step_d;
            armed_q     <= armed_d;
            init_done_q <= init_done_d;
            rs_q        <= rs_d;
            nib_q       <= nib_d;
            lo_q        <= lo_d;
            second_q    <= second_d;
        end
    end

    assign LCD_E     = (state_q == N_HIGH);
    assign LCD_RS    = rs_q;
    assign LCD_D     = nib_q;
    assign LCD_R_nW  = 1'b0;
    assign Ready     = (state_q == IDLE) && init_done_q;
    assign Init_Done = init_done_q;

endmodule

// File: tb/tb_lv_lcd_controller.sv
// tb_lv_lcd_controller: directed bench for lv_lcd_controller.
// Runs at 1 cycle = 1 us with a 2-cycle nibble phase. Every E pulse is
// checked against an expected queue of {RS, D, gap since the previous rise}.
module tb_lv_lcd_controller;

    localparam int E_CYC   = 2;
    localparam int PWR_CYC = 15000;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] Data;
    logic       RS_In;
    logic       Valid;
    logic       Ready;
    logic       Init_Done;
    logic       LCD_RS;
    logic       LCD_R_nW;
    logic       LCD_E;
    logic [3:0] LCD_D;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_rise = 0;

    logic [20:0] exp_q[$];   // {rs, d[3:0], gap[15:0]}; gap 0 = not checked

    lv_lcd_controller #(.CLK_KHZ(1000), .E_CYCLES(E_CYC)) dut (
        .Clk(Clk), .Reset(Reset), .Data(Data), .RS_In(RS_In), .Valid(Valid),
        .Ready(Ready), .Init_Done(Init_Done), .LCD_RS(LCD_RS),
        .LCD_R_nW(LCD_R_nW), .LCD_E(LCD_E), .LCD_D(LCD_D)
    );

    // Clock and cycle counter
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic rs, input logic [3:0] d, input int gap);
        exp_q.push_back({rs, d, 16'(gap)});
    endtask

    // Rise-to-rise gap across a step boundary with post-delay d
    function automatic int step_gap(input int d);
        return 3 * E_CYC + 1 + d;
    endfunction

    function automatic int user_delay(input logic rs, input logic [7:0] d);
`ifdef LCD_LONG_CMD_DETECT_EN
        return (!rs && (d[7:2] == 6'd0)) ? 1640 : 40;
`else
        return 1640;
`endif
    endfunction

    // Wait on a DUT output (0 Ready, 1 LCD_E, 2 Init_Done) with a cycle bound
    task automatic wait_sig(input int which, input int bound, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge Clk);
            if ((which == 0 && Ready) || (which == 1 && LCD_E) || (which == 2 && Init_Done)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s: signal still low after %0d cycles, required high", name, bound);
        end
    endtask

    // Monitor: sample just after the falling edge, pop one entry per E pulse
    bit       e_prev = 1'b0;
    int       high_len;
    bit       stable;
    logic     hi_rs;
    logic [3:0] hi_d;
    always begin
        logic [20:0] e;
        @(negedge Clk);
        #1;
        if (Reset) begin
            e_prev = 1'b0;
        end else begin
            if (LCD_E && !e_prev) begin
                high_len = 1;
                stable   = 1'b1;
                hi_rs    = LCD_RS;
                hi_d     = LCD_D;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_e_pulse: actual d=%0h rs=%0d required no pulse", LCD_D, LCD_RS);
                end else begin
                    e = exp_q.pop_front();
                    check("nibble_rs", int'(LCD_RS), int'(e[20]));
                    check("nibble_d", int'(LCD_D), int'(e[19:16]));
                    check("r_nw_low", int'(LCD_R_nW), 0);
                    if (e[15:0] != 16'd0) check("rise_gap", cyc - last_rise, int'(e[15:0]));
                end
                last_rise = cyc;
            end else if (LCD_E && e_prev) begin
                high_len++;
                if (LCD_RS != hi_rs || LCD_D != hi_d) stable = 1'b0;
            end else if (!LCD_E && e_prev) begin
                check("e_width", high_len, E_CYC);
                check("rs_d_stable_e_high", int'(stable), 1);
            end
            e_prev = LCD_E;
        end
    end

    // Outputs stay zero for the whole power-up wait, then the first strobe
    task automatic power_up_check(input string tag);
        int t0;
        int bad;
        bit ok;
        t0  = cyc;
        bad = 0;
        for (int k = 0; k < PWR_CYC; k++) begin
            if (k > 0) @(negedge Clk);
            if (LCD_E || LCD_RS || LCD_D != 4'd0 || LCD_R_nW || Ready || Init_Done) bad++;
        end
        check({tag, "_outputs_zero_cycles_bad"}, bad, 0);
        // PWR_WAIT, one INIT_STEP cycle, then E_CYC cycles of setup
        wait_sig(1, 100, {tag, "_first_e"}, ok);
        if (ok) check({tag, "_first_e_cycle"}, cyc - t0, PWR_CYC + 1 + E_CYC);
    endtask

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    // Stimulus
    initial begin
        int h;
        int h2;
        bit ok;
        Reset = 1'b1;
        Valid = 1'b0;
        Data  = 8'h00;
        RS_In = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        // Init nibble stream, then the byte held on Valid since power-up
        push_exp(0, 4'h3, 0);
        push_exp(0, 4'h3, step_gap(4100));
        push_exp(0, 4'h3, step_gap(100));
        push_exp(0, 4'h2, step_gap(100));
        push_exp(0, 4'h2, step_gap(100));
        push_exp(0, 4'h8, 3 * E_CYC);
        push_exp(0, 4'h0, step_gap(40));
        push_exp(0, 4'h8, 3 * E_CYC);
        push_exp(0, 4'h0, step_gap(40));
        push_exp(0, 4'h1, 3 * E_CYC);
        push_exp(0, 4'h0, step_gap(1640));
        push_exp(0, 4'h6, 3 * E_CYC);
        push_exp(0, 4'h0, step_gap(40));
        push_exp(0, 4'hC, 3 * E_CYC);
        push_exp(1, 4'h4, 0);
        push_exp(1, 4'h1, 3 * E_CYC);
        Valid = 1'b1;
        RS_In = 1'b1;
        Data  = 8'h41;
        power_up_check("pwr1");

        wait_sig(2, 12000, "init_done", ok);
        check("ready_with_init_done", int'(Ready), 1);
        check("init_done_after_last_rise", cyc - last_rise, 2 * E_CYC + 40);
        check("queue_left_at_init_done", exp_q.size(), 2);

        // Held Valid is accepted on the first Ready cycle
        h = cyc;
        @(negedge Clk);
        check("ready_drop_0x41", int'(Ready), 0);
        Valid = 1'b0;
        wait_sig(1, 50, "e_0x41", ok);
        check("e_rise_after_hs_0x41", cyc - h, 1 + E_CYC);
        wait_sig(0, 3000, "ready_0x41", ok);
        check("ready_return_0x41", cyc - h, 6 * E_CYC + 1 + user_delay(1'b1, 8'h41));

        // Clear command, with the next byte held on Valid behind it
        h = cyc;
        Valid = 1'b1;
        RS_In = 1'b0;
        Data  = 8'h01;
        push_exp(0, 4'h0, 0);
        push_exp(0, 4'h1, 3 * E_CYC);
        @(negedge Clk);
        check("ready_drop_clear", int'(Ready), 0);
        Data = 8'h80;
        push_exp(0, 4'h8, 0);
        push_exp(0, 4'h0, 3 * E_CYC);
        wait_sig(0, 3000, "ready_clear", ok);
        check("ready_return_clear", cyc - h, 6 * E_CYC + 1 + user_delay(1'b0, 8'h01));
        h2 = cyc;
        @(negedge Clk);
        check("ready_drop_0x80", int'(Ready), 0);
        Valid = 1'b0;
        wait_sig(1, 50, "e_0x80", ok);
        check("held_valid_accept_e_cycle", cyc - h2, 1 + E_CYC);
        wait_sig(0, 3000, "ready_0x80", ok);
        check("ready_return_0x80", cyc - h2, 6 * E_CYC + 1 + user_delay(1'b0, 8'h80));

        // Reset during the high nibble strobe of a user byte
        Valid = 1'b1;
        RS_In = 1'b1;
        Data  = 8'h48;
        push_exp(1, 4'h4, 0);
        @(negedge Clk);
        Valid = 1'b0;
        wait_sig(1, 50, "e_0x48", ok);
        @(negedge Clk);
        check("e_still_high_before_reset", int'(LCD_E), 1);
        Reset = 1'b1;
        exp_q.delete();
        @(negedge Clk);
        check("reset_e_low", int'(LCD_E), 0);
        check("reset_ready_low", int'(Ready), 0);
        check("reset_init_done_low", int'(Init_Done), 0);
        Reset = 1'b0;
        push_exp(0, 4'h3, 0);
        push_exp(0, 4'h3, step_gap(4100));
        power_up_check("pwr2");
        for (int i = 0; i < 6000 && exp_q.size() != 0; i++) @(negedge Clk);
        check("queue_drained_after_reset", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
